// File: rtl/soma_pkg.sv
// soma_pkg: shared definitions for the range-sum sequencer.
// Contents:
//   - SOMA_ADDR_W     : default RAM address width
//   - CYCLES_PER_WORD : cycles spent per summed word (ADDR, RD, LD, HOLD, GAP)
//   - WB_CYCLES       : write-back tail length, used with the per-word cost
//                       to express end-to-end latency
//   - ST_*            : FSM state encodings
//   - count_legal()   : range check of a requested word count
package soma_pkg;

  localparam int SOMA_ADDR_W     = 5;
  localparam int CYCLES_PER_WORD = 5;
  localparam int WB_CYCLES       = 5;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_CLR  = 4'd1;
  localparam logic [3:0] ST_ADDR = 4'd2;
  localparam logic [3:0] ST_RD   = 4'd3;
  localparam logic [3:0] ST_LD   = 4'd4;
  localparam logic [3:0] ST_HOLD = 4'd5;
  localparam logic [3:0] ST_GAP  = 4'd6;
  localparam logic [3:0] ST_XFER = 4'd7;
  localparam logic [3:0] ST_XGAP = 4'd8;
  localparam logic [3:0] ST_WR   = 4'd9;
  localparam logic [3:0] ST_WGAP = 4'd10;
  localparam logic [3:0] ST_DONE = 4'd11;

  // A run must cover at least one word and at most the whole RAM.
  function automatic logic count_legal(input int unsigned cnt,
                                       input int unsigned addr_w);
    return (cnt != 0) && (cnt <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/soma_addr_counter.sv
// soma_addr_counter: holds the latched base address and word count of a run
// and tracks the current word index k.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset (index only)
//   load            : latch base_in/count_in and restart at k = 0
//   advance         : step to the next word
//   base_in         : first word address
//   count_in        : number of words in the run
//   addr            : base + k, modulo the RAM depth
//   addr_nxt        : base + k + 1, modulo the RAM depth
//   last            : current word is the final one (k == count - 1)
module soma_addr_counter
  import soma_pkg::*;
#(
  parameter int ADDR_W = SOMA_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [CNT_W-1:0]  count_in,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_nxt,
  output logic              last
);

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  k_q;

  // Configuration is plain data; it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (load) begin
      base_q  <= base_in;
      count_q <= count_in;
    end
  end

  // The index is CNT_W wide so a full sweep (count = depth) still reaches
  // k = depth - 1 without aliasing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q <= '0;
    end else if (load) begin
      k_q <= '0;
    end else if (advance) begin
      k_q <= k_q + 1'b1;
    end
  end

  // Truncation of the sum gives the wrap-around for free.
  assign addr     = base_q + k_q[ADDR_W-1:0];
  assign addr_nxt = addr + 1'b1;
  assign last     = (k_q == count_q - 1'b1);

endmodule

// File: rtl/soma_range_ctrl.sv
// soma_range_ctrl: sequencer for the RAM/accumulator/write-back datapath.
// Sums `count` consecutive RAM words starting at `base_addr` (wrapping at the
// RAM depth), then writes the sum to `dest_addr` and pulses `ready`.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   start       : run request, honoured only while idle
//   base_addr   : first word address          (latched on accepted start)
//   count       : number of words, 1..2^ADDR_W (latched on accepted start)
//   dest_addr   : write-back address          (latched on accepted start)
//   busy        : a run is in progress (CLR through DONE)
//   ready       : one-cycle completion pulse
//   err         : one-cycle pulse for a start with an illegal count
//   address     : RAM address
//   rden        : RAM read enable
//   load        : accumulator load of RAM data
//   transf      : accumulator to write-back register transfer
//   wren        : RAM write enable
//   clear       : accumulator clear
// Every output is a register decoded from the next state, so strobes change
// only on clock edges and reset forces them low immediately.
module soma_range_ctrl
  import soma_pkg::*;
#(
  parameter int ADDR_W = SOMA_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              ready,
  output logic              err,
  output logic [ADDR_W-1:0] address,
  output logic              rden,
  output logic              load,
  output logic              transf,
  output logic              wren,
  output logic              clear
);

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] dest_q;
  logic              err_d;
  logic              ctr_load, ctr_adv, ctr_last;
  logic [ADDR_W-1:0] ctr_addr, ctr_addr_nxt;

  soma_addr_counter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .advance  (ctr_adv),
    .base_in  (base_addr),
    .count_in (count),
    .addr     (ctr_addr),
    .addr_nxt (ctr_addr_nxt),
    .last     (ctr_last)
  );

  always_ff @(posedge clk) begin
    if (ctr_load) begin
      dest_q <= dest_addr;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = address;
    err_d    = 1'b0;
    ctr_load = 1'b0;
    ctr_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count_legal(32'(count), ADDR_W)) begin
            state_d  = ST_CLR;
            ctr_load = 1'b1;
            addr_d   = base_addr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // The counter was loaded on entry to CLR, so ctr_addr is base here.
      ST_CLR: begin
        state_d = ST_ADDR;
        addr_d  = ctr_addr;
      end
      ST_ADDR: state_d = ST_RD;
      ST_RD:   state_d = ST_LD;
      ST_LD:   state_d = ST_HOLD;
      ST_HOLD: state_d = ST_GAP;
      // The index steps on the same edge that presents the next address, so
      // the address register takes addr_nxt rather than addr.
      ST_GAP: begin
        if (ctr_last) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_ADDR;
          ctr_adv = 1'b1;
          addr_d  = ctr_addr_nxt;
        end
      end
      ST_XFER: begin
        state_d = ST_XGAP;
        addr_d  = dest_q;
      end
      ST_XGAP: state_d = ST_WR;
      ST_WR:   state_d = ST_WGAP;
      ST_WGAP: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      address <= '0;
      rden    <= 1'b0;
      load    <= 1'b0;
      transf  <= 1'b0;
      wren    <= 1'b0;
      clear   <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      address <= addr_d;
      rden    <= (state_d == ST_RD) || (state_d == ST_LD) || (state_d == ST_HOLD);
      load    <= (state_d == ST_LD);
      transf  <= (state_d == ST_XFER);
      wren    <= (state_d == ST_WR);
      clear   <= (state_d == ST_CLR);
      busy    <= (state_d != ST_IDLE);
      ready   <= (state_d == ST_DONE);
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_soma_range_ctrl.sv
// tb_soma_range_ctrl: self-checking bench for soma_range_ctrl.
// A behavioural RAM/accumulator/write-back model reacts to the strobes.
// Expected read addresses, write address/data and latencies are queued when a
// run is launched and popped as the DUT produces the corresponding events.
module tb_soma_range_ctrl;
  import soma_pkg::*;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] count;
  logic [4:0] dest_addr;
  logic       busy, ready, err, rden, load, transf, wren, clear;
  logic [4:0] address;

  soma_range_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .dest_addr (dest_addr),
    .busy      (busy),
    .ready     (ready),
    .err       (err),
    .address   (address),
    .rden      (rden),
    .load      (load),
    .transf    (transf),
    .wren      (wren),
    .clear     (clear)
  );

  always #5 clk = ~clk;

  int unsigned ram [DEPTH];
  int unsigned acc, wb;
  int          rdq[$];
  int          wra[$];
  int unsigned wrd[$];
  int          latq[$];

  int nchk = 0, npass = 0;
  int ncyc = 0, e0 = 0;
  int viol = 0, extra = 0, err_cnt = 0, act_cnt = 0, wren_cnt = 0;
  bit ready_seen = 1'b0;

  logic       p_rden, p_load, p_transf, p_wren;
  logic [4:0] p_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    ncyc++;
  end

  // Monitor, scoreboard consumer and datapath model, all sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      p_rden = 1'b0; p_load = 1'b0; p_transf = 1'b0; p_wren = 1'b0; p_addr = '0;
    end else begin
      if ((address != p_addr) && (rden != p_rden)) viol++;
      if (load && !p_load && !p_rden) viol++;
      if (!rden && p_rden && p_load) viol++;
      if (load && transf) viol++;
      if ((wren != p_wren) && (transf || p_transf)) viol++;

      if (load) begin
        if (rdq.size() == 0) extra++;
        else chk("rd_addr", 32'(address), rdq.pop_front());
      end
      if (wren && !p_wren) begin
        if (wra.size() == 0) extra++;
        else begin
          chk("wr_addr", 32'(address), wra.pop_front());
          chk("wr_data", wb, wrd.pop_front());
        end
      end
      if (ready) begin
        if (latq.size() == 0) extra++;
        else chk("latency", ncyc - e0, latq.pop_front());
        ready_seen = 1'b1;
      end
      if (err) err_cnt++;
      if (wren) wren_cnt++;
      if (rden | load | transf | wren | clear | busy) act_cnt++;

      if (clear)  acc = 0;
      if (load)   acc = acc + ram[address];
      if (transf) wb = acc;
      if (wren)   ram[address] = wb;

      p_rden = rden; p_load = load; p_transf = transf; p_wren = wren; p_addr = address;
    end
  end

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && !ready_seen; i++) begin
      @(negedge clk);
      #1;
    end
    if (!ready_seen) chk("ready_timeout", 32'(ready_seen), 32'd1);
  endtask

  task automatic run(input int b, input int n, input int d, input bit disturb);
    int unsigned sum;
    int a;
    sum = 0;
    for (int k = 0; k < n; k++) begin
      a = (b + k) % DEPTH;
      rdq.push_back(a);
      sum = sum + ram[a];
    end
    wra.push_back(d);
    wrd.push_back(sum);
    latq.push_back(CYCLES_PER_WORD * n + WB_CYCLES);
    ready_seen = 1'b0;
    @(posedge clk); #2;
    base_addr = 5'(b); count = 6'(n); dest_addr = 5'(d); start = 1'b1;
    e0 = ncyc + 1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("clr_state", 32'({busy, clear, address}), 32'({2'b11, 5'(b)}));
    if (disturb) begin
      repeat (2) @(posedge clk); #2;
      base_addr = 5'd20; count = 6'd7; dest_addr = 5'd9; start = 1'b1;
      repeat (5) @(posedge clk); #2;
      start = 1'b0;
    end
    wait_ready(CYCLES_PER_WORD * n + 30);
    @(negedge clk); #1;
    chk("idle_after", 32'({busy, ready, rden, wren}), 32'd0);
    chk("ram_dest", ram[d], sum);
  endtask

  task automatic err_case(input int n);
    int e_before, a_before;
    e_before = err_cnt;
    a_before = act_cnt;
    @(posedge clk); #2;
    base_addr = 5'd3; count = 6'(n); dest_addr = 5'd4; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("err_now", 32'({err, busy}), 32'd2);
    repeat (4) @(posedge clk); #2;
    chk("err_pulse", err_cnt - e_before, 32'd1);
    chk("err_quiet", act_cnt - a_before, 32'd0);
  endtask

  task automatic reset_mid_run();
    int nl, w0;
    int unsigned saved;
    saved = ram[12];
    rdq.push_back(4); rdq.push_back(5); rdq.push_back(6);
    @(posedge clk); #2;
    base_addr = 5'd4; count = 6'd5; dest_addr = 5'd12; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    nl = 0;
    for (int i = 0; i < 60 && nl < 3; i++) begin
      @(negedge clk); #1;
      if (load) nl++;
    end
    chk("ld2_reached", nl, 32'd3);
    w0 = wren_cnt;
    reset = 1'b0;
    #1;
    chk("rst_async", 32'({address, busy, ready, err, rden, load, transf, wren, clear}), 32'd0);
    repeat (2) @(posedge clk); #2;
    reset = 1'b1;
    repeat (40) @(posedge clk); #2;
    chk("no_wr_after_rst", wren_cnt - w0, 32'd0);
    chk("idle_after_rst", 32'(busy), 32'd0);
    chk("ram_untouched", ram[12], saved);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; count = '0; dest_addr = '0;
    acc = 0; wb = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom_range(1, 1000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'({address, busy, ready, err, rden, load, transf, wren, clear}), 32'd0);
    #1;
    reset = 1'b1;

    run(0, 1, 5, 1'b0);
    run(0, 32, 0, 1'b0);
    run(30, 4, 31, 1'b0);
    err_case(0);
    err_case(33);
    err_case(63);
    run(10, 3, 2, 1'b1);
    repeat (10) @(posedge clk); #2;
    chk("no_second_run", 32'(busy), 32'd0);
    reset_mid_run();
    run(7, 2, 20, 1'b0);

    repeat (3) @(posedge clk); #2;
    chk("rdq_empty", rdq.size(), 32'd0);
    chk("wrq_empty", wra.size(), 32'd0);
    chk("latq_empty", latq.size(), 32'd0);
    chk("unexpected_events", extra, 32'd0);
    chk("spacing", viol, 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/soma_range_ctrl.md
Name: soma_range_ctrl

Overview:
- Programmable sequencer for the memory-accumulator datapath (RAM + accumulator + write-back register).
- On `start`, sums `count` consecutive RAM words beginning at `base_addr`, with wrap-around modulo 2^ADDR_W. It then writes the sum to `dest_addr` and pulses `ready`.
- Drives the same strobes as the fixed full-sweep FSM (address, rden, load, transf, wren, clear) with identical spacing rules. It replaces that FSM when a partial range or a relocated destination is needed.

Parameters:
- ADDR_W, 5, RAM address width; RAM depth = 2^ADDR_W.
- CNT_W, 6, width of `count`; must be ADDR_W+1 so a full sweep can be expressed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on accepted start.
- count  in  CNT_W  number of words, legal 1..2^ADDR_W; latched on accepted start.
- dest_addr  in  ADDR_W  write-back address; latched on accepted start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- ready  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when start is rejected for an illegal count.
- address  out  ADDR_W  RAM address.
- rden  out  1  RAM read enable.
- load  out  1  accumulator load of RAM data.
- transf  out  1  transfer of accumulator to write-back register.
- wren  out  1  RAM write enable.
- clear  out  1  accumulator clear.

Behaviour:
- All outputs are registered (Moore). On reset low, immediately: state=IDLE, address=0, and every strobe, busy, ready and err =0. Reset mid-run abandons the run; no write occurs.
- IDLE:
  - start=1 with 1<=count<=2^ADDR_W: latch the configuration, go to CLR.
  - start=1 with count=0 or count>2^ADDR_W: err=1 for one cycle, stay in IDLE.
  - start is ignored outside IDLE. Input changes while busy have no effect.
- CLR: clear=1 for one cycle; address = base_addr.
- Per-word loop, word k = 0..N-1. Each step is one cycle:
  - ADDR: address = (base+k) mod 2^ADDR_W; all strobes 0.
  - RD: rden=1.
  - LD: rden=1, load=1.
  - HOLD: rden=1, load=0.
  - GAP: rden=0, address unchanged.
  - After GAP: if k<N-1, go to ADDR with k+1; otherwise go to XFER.
- Write-back, one cycle each:
  - XFER: transf=1.
  - XGAP: transf=0, address = dest_addr.
  - WR: wren=1.
  - WGAP: wren=0.
  - DONE: ready=1, then IDLE.
- Guaranteed spacing, which the bench checks:
  - address never changes within one cycle of any rden edge;
  - rden rises >=1 cycle before load rises;
  - rden falls >=1 cycle after load falls;
  - load and transf are never high together;
  - wren edges are >=1 cycle from any transf edge, and transf=0 whenever wren changes.
- Latency: start sampled at edge E0 -> CLR at E0, ADDR(k) at E0+1+5k, XFER at E0+1+5N, DONE (ready high) at E0+5N+5.
  - N=1 gives 10 cycles; N=32 gives 165 cycles.
- Wrap: base=30, N=4 reads addresses 30, 31, 0, 1.
- The word counter is CNT_W bits wide, so N=2^ADDR_W terminates correctly without aliasing to 0.
- dest_addr may lie inside the summed range. The write occurs after all reads, so there is no hazard.

Decomposition:
- Shared package `soma_pkg`:
  - state encoding localparams (IDLE, CLR, ADDR, RD, LD, HOLD, GAP, XFER, XGAP, WR, WGAP, DONE);
  - ADDR_W default;
  - CYCLES_PER_WORD=5 and WB_CYCLES=5 constants, for bench latency checks.
- One sub-module `soma_addr_counter`: holds base/count, supplies the current address (base+k mod depth) and a `last` flag, with load/advance controls.

Test Plan:
- reset low for 2 cycles, release; base=0, count=1, dest=5, start pulse -> address 0 during RD/LD/HOLD; address=5 with wren=1 in WR; ready at cycle 10; busy=0 after.
- base=0, count=32, dest=0 -> 32 read windows at addresses 0..31; ready at cycle 165; the spacing monitor reports no violation.
- base=30, count=4, dest=31 -> read addresses 30, 31, 0, 1 in order; write at 31; RAM[31] = sum of the four preloaded words.
- count=0, then count=33 -> err one-cycle pulse each time; busy stays 0; no strobe toggles.
- start re-pulsed and base/count changed during a count=3 run -> the run completes with the original config; ready at cycle 20; no second run starts.
- reset asserted during the LD cycle of word 2 -> all strobes 0 in the same cycle; no wren pulse; after release, a new start runs normally.
